// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Timing bundle produced by vga_sync_gen and consumed by the
//               pixel generation circuit / VGA connector.
//                 hsync, vsync   active-low sync pulses
//                 video_on       current pixel is in the visible area
//                 p_tick         one-clk strobe, counters advance this cycle
//                 frame_tick     one-clk strobe coincident with pixel (0,0)
//                 pixel_x/_y     current column / line
//               master: timing generator side, slave: consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;

  modport master (
    output hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
  );

  modport slave (
    input  hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Free-running 640x480@60Hz VGA timing generator. The system
//               clock is divided by CLK_DIV to form the pixel rate; column and
//               line counters drive pixel_x/pixel_y, and sync/blanking flags
//               are registered from the next counter values so every output
//               changes on the same clock edge.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active-low (0 = reset)
//               vga  - timing bundle (master modport), see vga_sync_gen_if
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  wire logic          clk,
  input  wire logic          rst,
  vga_sync_gen_if.master     vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] C_DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       C_H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       C_V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       C_H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]       C_V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]       C_HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       C_HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]       C_VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       C_VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_tick_q, frame_tick_d;
  logic             p_tick;

  // Pixel strobe is a plain decode of the divider register, so it is
  // glitch-free and lines up with the edge on which the counters move.
  assign p_tick = (div_q == C_DIV_MAX);

  always_comb begin
    div_d        = p_tick ? '0 : div_q + DIV_W'(1);
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    frame_tick_d = 1'b0;

    if (p_tick) begin
      if (h_cnt_q == C_H_MAX) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == C_V_MAX) ? '0 : v_cnt_q + 10'd1;
        // Registered so the pulse lands together with the (0,0) counters.
        frame_tick_d = (v_cnt_q == C_V_MAX);
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end

    // Decode from the next counter values: the registered flags then
    // describe the same pixel as pixel_x/pixel_y after the edge.
    hsync_d    = !((h_cnt_d >= C_HS_START) && (h_cnt_d <= C_HS_END));
    vsync_d    = !((v_cnt_d >= C_VS_START) && (v_cnt_d <= C_VS_END));
    video_on_d = (h_cnt_d < C_H_VIS) && (v_cnt_d < C_V_VIS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.p_tick     = p_tick;
  assign vga.frame_tick = frame_tick_q;
  assign vga.pixel_x    = h_cnt_q;
  assign vga.pixel_y    = v_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Scoreboard bench for vga_sync_gen. Three instances share one
//               clock and reset: default timing, CLK_DIV=2 with default
//               timing, and a tiny frame (CLK_DIV=3) so whole frames and the
//               vsync region fit in a short run. Expected outputs come from a
//               reference model that maps "edges since reset release" to a
//               pixel index with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  localparam exp_t C_RST = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0,
                             p_tick: 1'b0, frame_tick: 1'b0, x: 10'd0, y: 10'd0};

  // Small instance geometry: 25 x 12 pixels, 3 clk per pixel -> 900 clk frame
  localparam int S_DIV = 3;
  localparam int S_HD = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VD = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = S_DIV * (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen_if vif0 ();
  vga_sync_gen_if vif1 ();
  vga_sync_gen_if vif2 ();

  vga_sync_gen u_dut0 (.clk(clk), .rst(rst), .vga(vif0));

  vga_sync_gen #(.CLK_DIV(2)) u_dut1 (.clk(clk), .rst(rst), .vga(vif1));

  vga_sync_gen #(
    .CLK_DIV(S_DIV),
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_dut2 (.clk(clk), .rst(rst), .vga(vif2));

  int total = 0;
  int bad   = 0;

  exp_t q0[$], q1[$], q2[$];
  int   n_edges = 0;

  // Reference: n = rising edges since reset release. Pixel n/cd of an
  // endless raster scan; outputs are pure functions of that pixel.
  function automatic exp_t model(int n, int cd, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb);
    exp_t e;
    int ht, vt, idx, x, y;
    if (n == 0) return C_RST;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    idx = (n / cd) % (ht * vt);
    x   = idx % ht;
    y   = idx / ht;
    e.hsync      = !(x >= hd + hf && x < hd + hf + hs);
    e.vsync      = !(y >= vd + vf && y < vd + vf + vs);
    e.video_on   = (x < hd) && (y < vd);
    e.p_tick     = (n % cd) == cd - 1;
    e.frame_tick = (n % (cd * ht * vt)) == 0;
    e.x          = 10'(x);
    e.y          = 10'(y);
    return e;
  endfunction

  task automatic check(string name, exp_t act, exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ft=%b want x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ft=%b",
               name, $time, act.x, act.y, act.hsync, act.vsync, act.video_on, act.p_tick,
               act.frame_tick, exp.x, exp.y, exp.hsync, exp.vsync, exp.video_on,
               exp.p_tick, exp.frame_tick);
    end
  endtask

  function automatic exp_t snap0();
    return {vif0.hsync, vif0.vsync, vif0.video_on, vif0.p_tick, vif0.frame_tick, vif0.pixel_x, vif0.pixel_y};
  endfunction
  function automatic exp_t snap1();
    return {vif1.hsync, vif1.vsync, vif1.video_on, vif1.p_tick, vif1.frame_tick, vif1.pixel_x, vif1.pixel_y};
  endfunction
  function automatic exp_t snap2();
    return {vif2.hsync, vif2.vsync, vif2.video_on, vif2.p_tick, vif2.frame_tick, vif2.pixel_x, vif2.pixel_y};
  endfunction

  // Producer: on every rising edge, push what each DUT should show after it.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) n_edges = 0;
      else      n_edges++;
      q0.push_back(model(n_edges, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      q1.push_back(model(n_edges, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      q2.push_back(model(n_edges, S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB));
    end
  end

  // Monitor: every falling edge the DUTs present a new sample; pop and compare.
  int ft_gap = -1;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty t=%0t got sizes %0d/%0d/%0d want >0", $time, q0.size(), q1.size(), q2.size());
      end else begin
        e = q0.pop_front(); check("dut0_div4", snap0(), e);
        e = q1.pop_front(); check("dut1_div2", snap1(), e);
        e = q2.pop_front(); check("dut2_small", snap2(), e);
      end
      // Frame period of the small instance, measured from its own pulses.
      if (!rst) begin
        ft_gap = -1;
      end else begin
        if (ft_gap >= 0) ft_gap++;
        if (vif2.frame_tick) begin
          if (ft_gap > 0) begin
            total++;
            if (ft_gap != S_FRAME) begin
              bad++;
              $display("FAIL frame_period got %0d want %0d", ft_gap, S_FRAME);
            end
          end
          ft_gap = 0;
        end
      end
    end
  end

  task automatic release_rst();
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  // Async reset between edges; outputs must drop before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b0;
    #1;
    check("async_rst0", snap0(), C_RST);
    check("async_rst1", snap1(), C_RST);
    check("async_rst2", snap2(), C_RST);
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_rst0", snap0(), C_RST);
    check("in_rst2", snap2(), C_RST);
    release_rst();
    for (int seg = 0; seg < 8; seg++) begin
      repeat ($urandom_range(1500, 4000)) @(posedge clk);
      async_reset();
      release_rst();
    end
    // Long run: several default lines, many small frames.
    repeat (16000) @(posedge clk);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
